iq_tx_serializer: RTL

IQ_TX_SERIALIZER -- requirements
Module: iq_tx_serializer

---
 rtl/iq_tx_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/iq_tx_serializer.sv
// Formats complex FIFO words into 32-bit framed I/Q symbols and shifts them out as bit pairs.
// Latency: first pair 2 cycles after the IDLE read strobe; back-to-back frames after that.
// Backpressure: none downstream; reads only when the FIFO is non-empty, one prefetch per frame.
module iq_tx_serializer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tx_en_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_en_o,
  input  logic [2*DATA_WIDTH-1:0] fifo_data_i,
  output logic [1:0]              tx_data_o,
  output logic                    tx_active_o,
  output logic [7:0]              underrun_cnt_o
);

  localparam int SAMPLE_BITS = 13;
  localparam logic [3:0] PH_PREFETCH = 4'd13;
  localparam logic [3:0] PH_LAST     = 4'd15;
  localparam logic [2*DATA_WIDTH-1:0] LOW_MASK =
      {{(2*DATA_WIDTH-SAMPLE_BITS){1'b0}}, {SAMPLE_BITS{1'b1}}};
  localparam logic [2*DATA_WIDTH-1:0] USED_MASK = (LOW_MASK << DATA_WIDTH) | LOW_MASK;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  phase_q;
  logic [31:0] shift_q;
  logic [31:0] hold_q;
  logic        hold_vld_q;
  logic        fetch_pend_q;
  logic [7:0]  underrun_q;
  logic        rd_en;
  logic        unused_bits;

  // Only the low 13 bits of each half reach the line; sync/marker bits are fixed.
  function automatic logic [31:0] fmt_frame(input logic [2*DATA_WIDTH-1:0] w);
    return {2'b10, w[DATA_WIDTH +: SAMPLE_BITS], 1'b0,
            2'b01, w[SAMPLE_BITS-1:0],           1'b0};
  endfunction

  assign unused_bits = ^(fifo_data_i & ~USED_MASK);

  always_comb begin
    state_d     = state_q;
    rd_en       = 1'b0;
    tx_active_o = 1'b0;
    tx_data_o   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty_i) begin
          rd_en   = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        state_d = STREAM;
      end
      STREAM: begin
        tx_active_o = 1'b1;
        tx_data_o   = shift_q[31:30];
        if (phase_q == PH_PREFETCH && tx_en_i && !fifo_empty_i && !hold_vld_q) begin
          rd_en = 1'b1;
        end
        if (phase_q == PH_LAST && !hold_vld_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs sit at their reset values for the whole time reset is held.
    if (rst_i) begin
      rd_en       = 1'b0;
      tx_active_o = 1'b0;
      tx_data_o   = 2'b00;
    end
  end

  assign fifo_rd_en_o   = rd_en;
  assign underrun_cnt_o = rst_i ? 8'd0 : underrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      phase_q      <= 4'd0;
      shift_q      <= 32'd0;
      hold_q       <= 32'd0;
      hold_vld_q   <= 1'b0;
      fetch_pend_q <= 1'b0;
      underrun_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      fetch_pend_q <= rd_en && (state_q == STREAM);
      unique case (state_q)
        PRIME: begin
          shift_q <= fmt_frame(fifo_data_i);
          phase_q <= 4'd0;
        end
        STREAM: begin
          phase_q <= phase_q + 4'd1;
          shift_q <= {shift_q[29:0], 2'b00};
          // Prefetch data is on the bus the cycle after the phase-13 strobe.
          if (fetch_pend_q) begin
            hold_q     <= fmt_frame(fifo_data_i);
            hold_vld_q <= 1'b1;
          end
          if (phase_q == PH_LAST) begin
            if (hold_vld_q) begin
              shift_q    <= hold_q;
              hold_vld_q <= 1'b0;
            end else if (tx_en_i && underrun_q != 8'hFF) begin
              underrun_q <= underrun_q + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
